// File: rtl/msg_schedule.sv
// Message schedule generator: loads a 16-word chunk, then presents W[t] and K[t]
// for 64 rounds of four cycles each, pulsing update_o when the chunk is done.
module msg_schedule (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        word_valid_i,
    input  logic [31:0] word_i,
    output logic        word_ready_o,
    output logic [31:0] w_o,
    output logic [31:0] k_o,
    output logic [5:0]  round_o,
    output logic        busy_o,
    output logic        update_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        UPD  = 2'd2
    } state_t;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t      state_q, state_d;
    logic [3:0]  loadCnt_q, loadCnt_d;
    logic [5:0]  round_q, round_d;
    logic [1:0]  phase_q, phase_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] newWord;
    logic        shiftEn;
    logic [31:0] shiftIn;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[0..15] always holds W[t..t+15], so the recurrence only needs fixed taps.
    assign newWord = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d   = state_q;
        loadCnt_d = loadCnt_q;
        round_d   = round_q;
        phase_d   = phase_q;
        shiftEn   = 1'b0;
        shiftIn   = '0;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end

        if (clr_i) begin
            state_d   = IDLE;
            loadCnt_d = '0;
            round_d   = '0;
            phase_d   = '0;
            for (int i = 0; i < 16; i++) begin
                win_d[i] = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (word_valid_i) begin
                        shiftEn = 1'b1;
                        shiftIn = word_i;
                        if (loadCnt_q == 4'd15) begin
                            loadCnt_d = '0;
                            state_d   = RUN;
                            round_d   = '0;
                            phase_d   = '0;
                        end else begin
                            loadCnt_d = loadCnt_q + 4'd1;
                        end
                    end
                end
                RUN: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        shiftEn = 1'b1;
                        shiftIn = newWord;
                        if (round_q == 6'd63) begin
                            state_d = UPD;
                            round_d = '0;
                        end else begin
                            round_d = round_q + 6'd1;
                        end
                    end
                end
                UPD:     state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (shiftEn) begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i + 1];
                end
                win_d[15] = shiftIn;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            loadCnt_q <= '0;
            round_q   <= '0;
            phase_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            loadCnt_q <= loadCnt_d;
            round_q   <= round_d;
            phase_q   <= phase_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign word_ready_o = (state_q == IDLE) && !clr_i;
    assign w_o          = win_q[0];
    assign k_o          = K_TAB[round_q];
    assign round_o      = round_q;
    assign busy_o       = (state_q != IDLE);
    assign update_o     = (state_q == UPD);

endmodule

// File: tb/tb_msg_schedule.sv
// Bench for msg_schedule: a chunk-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_msg_schedule;

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        wordValid;
    logic [31:0] wordIn;
    logic        wordReady;
    logic [31:0] wOut;
    logic [31:0] kOut;
    logic [5:0]  roundOut;
    logic        busy;
    logic        update;

    int nChecks = 0;
    int nErrors = 0;
    bit checkEn = 0;

    // Model: last 16 window words, mode (0 idle, 1 run, 2 update), load count, run cycle.
    logic [31:0] hist [$];
    logic [31:0] wExp [80];
    int          mMode;
    int          mCnt;
    int          mCyc;

    logic [31:0] abcWords [16];

    msg_schedule dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .word_valid_i (wordValid),
        .word_i       (wordIn),
        .word_ready_o (wordReady),
        .w_o          (wOut),
        .k_o          (kOut),
        .round_o      (roundOut),
        .busy_o       (busy),
        .update_o     (update)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic modelClear();
        hist.delete();
        for (int i = 0; i < 16; i++) hist.push_back(32'h0);
        mMode = 0;
        mCnt  = 0;
        mCyc  = 0;
    endtask

    task automatic modelStartRun();
        for (int i = 0; i < 16; i++) wExp[i] = hist[i];
        for (int t = 16; t < 80; t++)
            wExp[t] = s1(wExp[t-2]) + wExp[t-7] + s0(wExp[t-15]) + wExp[t-16];
        mMode = 1;
        mCyc  = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            modelClear();
        end else if (mMode == 0) begin
            if (wordValid) begin
                hist.push_back(wordIn);
                void'(hist.pop_front());
                mCnt++;
                if (mCnt == 16) begin
                    mCnt = 0;
                    modelStartRun();
                end
            end
        end else if (mMode == 1) begin
            mCyc++;
            if (mCyc == 256) begin
                mMode = 2;
                for (int t = 64; t < 80; t++) begin
                    hist.push_back(wExp[t]);
                    void'(hist.pop_front());
                end
            end
        end else begin
            mMode = 0;
        end
    end

    task automatic checkOutput();
        logic [5:0]  expRound;
        logic [31:0] expW;
        expRound = (mMode == 1) ? 6'(mCyc / 4) : 6'd0;
        expW     = (mMode == 1) ? wExp[mCyc / 4] : hist[0];
        check("w_o", wOut, expW);
        check("k_o", kOut, K_REF[expRound]);
        check("round_o", {26'b0, roundOut}, {26'b0, expRound});
        check("busy_o", {31'b0, busy}, {31'b0, mMode != 0});
        check("update_o", {31'b0, update}, {31'b0, mMode == 2});
        check("word_ready_o", {31'b0, wordReady}, {31'b0, (mMode == 0) && !clr});
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic c);
        @(posedge clk);
        #1;
        wordValid = v;
        wordIn    = w;
        clr       = c;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " w_o"}, wOut, 32'h0);
        check({tag, " k_o"}, kOut, 32'h428a2f98);
        check({tag, " round_o"}, {26'b0, roundOut}, 32'h0);
        check({tag, " busy_o"}, {31'b0, busy}, 32'h0);
        check({tag, " update_o"}, {31'b0, update}, 32'h0);
        check({tag, " word_ready_o"}, {31'b0, wordReady}, 32'h1);
    endtask

    task automatic loadRandom(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, $urandom, 1'b0);
    endtask

    initial begin
        rst_n = 1; clr = 0; wordValid = 0; wordIn = 0;
        for (int i = 0; i < 16; i++) abcWords[i] = 32'h0;
        abcWords[0]  = 32'h61626380;
        abcWords[15] = 32'h00000018;

        #2 rst_n = 0;
        @(posedge clk); #1;
        checkEn = 1;
        checkResetValues("reset");
        @(posedge clk); #1 rst_n = 1;

        $display("[TB] abc chunk");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, abcWords[i], 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 259; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check("model W16", wExp[16], 32'h61626380);
                check("model W17", wExp[17], 32'h000f0000);
                check("abc busy at entry", {31'b0, busy}, 32'h1);
            end
            if (c >= 64 && c <= 67) begin
                check("abc W16", wOut, 32'h61626380);
                check("abc K16", kOut, 32'he49b69c1);
            end
            if (c >= 68 && c <= 71) check("abc W17", wOut, 32'h000f0000);
            if (c == 255) check("abc update early", {31'b0, update}, 32'h0);
            if (c == 256) check("abc update pulse", {31'b0, update}, 32'h1);
            if (c == 257) begin
                check("abc update end", {31'b0, update}, 32'h0);
                check("abc ready back", {31'b0, wordReady}, 32'h1);
            end
        end

        $display("[TB] toggling valid load");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, $urandom, 1'b0);
            applyStimulus(1'b0, $urandom, 1'b0);
        end
        for (int c = 0; c < 258; c++) begin
            @(negedge clk);
            if (c < 256) check("toggle round", {26'b0, roundOut}, 32'(c / 4));
            if (c == 256) check("toggle update", {31'b0, update}, 32'h1);
        end

        $display("[TB] words offered during run");
        loadRandom(16);
        applyStimulus(1'b1, $urandom, 1'b0);
        check("run ready low", {31'b0, wordReady}, 32'h0);
        for (int c = 0; c < 249; c++) applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (12) @(posedge clk);

        $display("[TB] clear at round 30");
        loadRandom(16);
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (120) applyStimulus(1'b0, 32'h0, 1'b0);
        check("round 30 reached", {26'b0, roundOut}, 32'd30);
        clr = 1;
        @(posedge clk); #1 clr = 0;
        check("clr round", {26'b0, roundOut}, 32'h0);
        check("clr w", wOut, 32'h0);
        check("clr busy", {31'b0, busy}, 32'h0);
        repeat (6) @(posedge clk);
        loadRandom(16);
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (258) @(posedge clk);

        $display("[TB] clear during partial load");
        loadRandom(7);
        applyStimulus(1'b1, 32'hdeadbeef, 1'b1);
        loadRandom(15);
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1 check("15 after clr idle", {31'b0, busy}, 32'h0);
        applyStimulus(1'b1, $urandom, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        #1 check("16 after clr run", {31'b0, busy}, 32'h1);
        repeat (258) @(posedge clk);

        $display("[TB] reset mid-run");
        loadRandom(16);
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (50) @(posedge clk);
        #3 rst_n = 0;
        #1 checkResetValues("async reset");
        @(posedge clk); #1 rst_n = 1;
        repeat (270) @(posedge clk);

        checkEn = 0;
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
